avl_port_arbiter: RTL and testbench

- Shares the single Avalon bus-master bridge of the MIPS CPU between the instruction-fetch port (I) and the load/store data port (D).
- Each requester sees a private request/busy interface.
- The arbiter serialises the requests and issues each one to the bridge as a one-cycle select pulse. It then holds the grant until the bridge reports completion, and keeps each port's last read result.
- Sits between the CPU core and the bridge front end.

---
 rtl/avl_port_arbiter_pkg.sv | 14 +
 rtl/avl_port_arbiter_rr_pick2.sv | 24 ++
 rtl/avl_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_avl_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/avl_port_arbiter_pkg.sv
// Shared types for the I/D Avalon bridge arbiter.
// Arbiter state encoding and port identifiers.
package avl_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/avl_port_arbiter_rr_pick2.sv
// Two-way chooser between the I and D requesters.
// Round-robin on conflict, or D-wins when FIXED_PRIORITY is set.
module rr_pick2
    import avl_port_arbiter_pkg::*;
#(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic req_i,
    input  logic req_d,
    input  logic last,
    output logic winner,
    output logic any
);

    always_comb begin
        any = req_i | req_d;
        if (req_i && req_d) begin
            winner = (FIXED_PRIORITY != 0) ? PORT_D : ~last;
        end else begin
            winner = req_d;
        end
    end

endmodule

// File: rtl/avl_port_arbiter.sv
// Shares one Avalon bus-master bridge between the CPU fetch (I) and load/store (D) ports.
// Each access is issued as a one-cycle select pulse; the grant is held until the bridge finishes.
module avl_port_arbiter
    import avl_port_arbiter_pkg::*;
#(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic            clk,
    input  logic            rst,

    input  logic [AW-1:0]   i_address,
    input  logic            i_read,
    input  logic            i_write,
    input  logic [DW-1:0]   i_write_data,
    input  logic [DW/8-1:0] i_byteenable,
    output logic [DW-1:0]   i_read_data,
    output logic            i_busy,

    input  logic [AW-1:0]   d_address,
    input  logic            d_read,
    input  logic            d_write,
    input  logic [DW-1:0]   d_write_data,
    input  logic [DW/8-1:0] d_byteenable,
    output logic [DW-1:0]   d_read_data,
    output logic            d_busy,

    output logic [AW-1:0]   dn_address,
    output logic [DW-1:0]   dn_write_data,
    output logic [DW/8-1:0] dn_byteenable,
    output logic            dn_read_select,
    output logic            dn_write_select,
    input  logic [DW-1:0]   dn_read_data,
    input  logic            dn_busy,

    output logic            grant
);

    arb_state_t      state_q, state_d;
    logic            grant_q, grant_d;
    logic            last_q, last_d;
    logic            op_read_q, op_read_d;
    logic [DW-1:0]   rdata_i_q, rdata_i_d;
    logic [DW-1:0]   rdata_d_q, rdata_d_d;

    logic req_i, req_d;
    logic rd_i, rd_d, wr_i, wr_d;
    logic winner, any;
    logic done;

    assign rd_i  = i_read & ~i_write;
    assign wr_i  = i_write & ~i_read;
    assign rd_d  = d_read & ~d_write;
    assign wr_d  = d_write & ~d_read;
    assign req_i = i_read ^ i_write;
    assign req_d = d_read ^ d_write;

    rr_pick2 #(
        .FIXED_PRIORITY(FIXED_PRIORITY)
    ) u_pick (
        .req_i  (req_i),
        .req_d  (req_d),
        .last   (last_q),
        .winner (winner),
        .any    (any)
    );

    assign done = (state_q == WAIT) && !dn_busy;

    // Address/data stay on the granted port in every state; the bridge needs the offset in WAIT.
    assign dn_address    = (grant_q == PORT_D) ? d_address    : i_address;
    assign dn_write_data = (grant_q == PORT_D) ? d_write_data : i_write_data;
    assign dn_byteenable = (grant_q == PORT_D) ? d_byteenable : i_byteenable;
    assign grant         = grant_q;

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        last_d          = last_q;
        op_read_d       = op_read_q;
        rdata_i_d       = rdata_i_q;
        rdata_d_d       = rdata_d_q;
        dn_read_select  = 1'b0;
        dn_write_select = 1'b0;

        case (state_q)
            IDLE: begin
                if (any) begin
                    grant_d   = winner;
                    op_read_d = (winner == PORT_D) ? rd_d : rd_i;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                dn_read_select  = (grant_q == PORT_D) ? rd_d : rd_i;
                dn_write_select = (grant_q == PORT_D) ? wr_d : wr_i;
                state_d         = WAIT;
            end
            WAIT: begin
                if (!dn_busy) begin
                    if (op_read_q) begin
                        if (grant_q == PORT_D) rdata_d_d = dn_read_data;
                        else                   rdata_i_d = dn_read_data;
                    end
                    last_d = grant_q;
                    // Hand straight to the other port; the finishing port's request is still visible now.
                    if ((grant_q == PORT_D) ? req_i : req_d) begin
                        grant_d   = ~grant_q;
                        op_read_d = (grant_q == PORT_D) ? rd_i : rd_d;
                        state_d   = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            grant_q   <= PORT_I;
            last_q    <= PORT_D;
            op_read_q <= 1'b0;
            rdata_i_q <= '0;
            rdata_d_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            op_read_q <= op_read_d;
            rdata_i_q <= rdata_i_d;
            rdata_d_q <= rdata_d_d;
        end
    end

    assign i_busy = req_i & ~(done && grant_q == PORT_I);
    assign d_busy = req_d & ~(done && grant_q == PORT_D);

    assign i_read_data = (done && grant_q == PORT_I && op_read_q) ? dn_read_data : rdata_i_q;
    assign d_read_data = (done && grant_q == PORT_D && op_read_q) ? dn_read_data : rdata_d_q;

endmodule

// File: tb/tb_avl_port_arbiter.sv
// Directed bench for avl_port_arbiter: a round-robin instance and a fixed-priority instance
// driven by the same requesters and bridge stimulus.
module tb_avl_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [31:0] i_address = '0, d_address = '0;
    logic        i_read = 1'b0, i_write = 1'b0, d_read = 1'b0, d_write = 1'b0;
    logic [31:0] i_write_data = '0, d_write_data = '0;
    logic [3:0]  i_byteenable = '0, d_byteenable = '0;
    logic [31:0] dn_read_data = '0;
    logic        dn_busy = 1'b0;

    logic [31:0] i_rdata0, d_rdata0, dn_addr0, dn_wdata0;
    logic [3:0]  dn_be0;
    logic        i_busy0, d_busy0, rsel0, wsel0, grant0;

    logic [31:0] i_rdata1, d_rdata1, dn_addr1, dn_wdata1;
    logic [3:0]  dn_be1;
    logic        i_busy1, d_busy1, rsel1, wsel1, grant1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    avl_port_arbiter #(.AW(32), .DW(32), .FIXED_PRIORITY(0)) dut0 (
        .clk(clk), .rst(rst),
        .i_address(i_address), .i_read(i_read), .i_write(i_write),
        .i_write_data(i_write_data), .i_byteenable(i_byteenable),
        .i_read_data(i_rdata0), .i_busy(i_busy0),
        .d_address(d_address), .d_read(d_read), .d_write(d_write),
        .d_write_data(d_write_data), .d_byteenable(d_byteenable),
        .d_read_data(d_rdata0), .d_busy(d_busy0),
        .dn_address(dn_addr0), .dn_write_data(dn_wdata0), .dn_byteenable(dn_be0),
        .dn_read_select(rsel0), .dn_write_select(wsel0),
        .dn_read_data(dn_read_data), .dn_busy(dn_busy),
        .grant(grant0)
    );

    avl_port_arbiter #(.AW(32), .DW(32), .FIXED_PRIORITY(1)) dut1 (
        .clk(clk), .rst(rst),
        .i_address(i_address), .i_read(i_read), .i_write(i_write),
        .i_write_data(i_write_data), .i_byteenable(i_byteenable),
        .i_read_data(i_rdata1), .i_busy(i_busy1),
        .d_address(d_address), .d_read(d_read), .d_write(d_write),
        .d_write_data(d_write_data), .d_byteenable(d_byteenable),
        .d_read_data(d_rdata1), .d_busy(d_busy1),
        .dn_address(dn_addr1), .dn_write_data(dn_wdata1), .dn_byteenable(dn_be1),
        .dn_read_select(rsel1), .dn_write_select(wsel1),
        .dn_read_data(dn_read_data), .dn_busy(dn_busy),
        .grant(grant1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks run 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
    endtask

    initial begin
        tick();
        tick();
        #1;
        chk("rst_grant", 32'(grant0), 32'd0);
        chk("rst_rsel", 32'(rsel0), 32'd0);
        chk("rst_wsel", 32'(wsel0), 32'd0);
        chk("rst_irdata", i_rdata0, 32'h0);
        chk("rst_drdata", d_rdata0, 32'h0);
        rst = 1'b1;

        // Lone I read, bridge busy for two WAIT cycles
        tick();
        i_read = 1'b1; i_address = 32'h100;
        #1;
        chk("t1_req_ibusy", 32'(i_busy0), 32'd1);
        chk("t1_req_rsel", 32'(rsel0), 32'd0);
        tick();
        dn_busy = 1'b1;
        #1;
        chk("t1_iss_rsel", 32'(rsel0), 32'd1);
        chk("t1_iss_addr", dn_addr0, 32'h100);
        chk("t1_iss_dbusy", 32'(d_busy0), 32'd0);
        tick();
        #1;
        chk("t1_w1_rsel", 32'(rsel0), 32'd0);
        chk("t1_w1_ibusy", 32'(i_busy0), 32'd1);
        chk("t1_w1_addr", dn_addr0, 32'h100);
        tick();
        #1;
        chk("t1_w2_ibusy", 32'(i_busy0), 32'd1);
        tick();
        dn_busy = 1'b0; dn_read_data = 32'hDEADBEEF;
        #1;
        chk("t1_done_ibusy", 32'(i_busy0), 32'd0);
        chk("t1_done_rdata", i_rdata0, 32'hDEADBEEF);
        chk("t1_done_dbusy", 32'(d_busy0), 32'd0);
        tick();
        i_read = 1'b0; dn_read_data = 32'h0;
        #1;
        chk("t1_hold_rdata", i_rdata0, 32'hDEADBEEF);
        chk("t1_idle_rsel", 32'(rsel0), 32'd0);

        // Simultaneous I read and D write straight after reset
        pulse_reset();
        i_read = 1'b1; i_address = 32'h200;
        d_write = 1'b1; d_address = 32'h300; d_write_data = 32'h12345678; d_byteenable = 4'hF;
        #1;
        chk("t2_req_ibusy", 32'(i_busy0), 32'd1);
        chk("t2_req_dbusy", 32'(d_busy0), 32'd1);
        tick();
        #1;
        chk("t2_iss_grant", 32'(grant0), 32'd0);
        chk("t2_iss_rsel", 32'(rsel0), 32'd1);
        chk("t2_iss_wsel", 32'(wsel0), 32'd0);
        chk("t2_iss_addr", dn_addr0, 32'h200);
        tick();
        dn_read_data = 32'hCAFE0001;
        #1;
        chk("t2_idone_ibusy", 32'(i_busy0), 32'd0);
        chk("t2_idone_dbusy", 32'(d_busy0), 32'd1);
        chk("t2_idone_rdata", i_rdata0, 32'hCAFE0001);
        tick();
        i_read = 1'b0;
        #1;
        chk("t2_diss_grant", 32'(grant0), 32'd1);
        chk("t2_diss_wsel", 32'(wsel0), 32'd1);
        chk("t2_diss_rsel", 32'(rsel0), 32'd0);
        chk("t2_diss_addr", dn_addr0, 32'h300);
        chk("t2_diss_wdata", dn_wdata0, 32'h12345678);
        chk("t2_diss_be", 32'(dn_be0), 32'hF);
        tick();
        #1;
        chk("t2_ddone_dbusy", 32'(d_busy0), 32'd0);
        chk("t2_ddone_drdata", d_rdata0, 32'h0);
        tick();
        d_write = 1'b0;
        i_read = 1'b1;
        tick();
        #1;
        chk("t2_ionly_grant", 32'(grant0), 32'd0);
        tick();
        tick();
        i_read = 1'b0;

        // Second conflict after I was served last: D first, then I back-to-back
        tick();
        i_read = 1'b1; d_read = 1'b1; d_address = 32'h400;
        tick();
        #1;
        chk("t3_iss_grant", 32'(grant0), 32'd1);
        chk("t3_iss_rsel", 32'(rsel0), 32'd1);
        chk("t3_iss_addr", dn_addr0, 32'h400);
        tick();
        dn_read_data = 32'hAA;
        #1;
        chk("t3_ddone_rdata", d_rdata0, 32'hAA);
        chk("t3_ddone_dbusy", 32'(d_busy0), 32'd0);
        chk("t3_ddone_ibusy", 32'(i_busy0), 32'd1);
        tick();
        d_read = 1'b0;
        #1;
        chk("t3_iiss_grant", 32'(grant0), 32'd0);
        chk("t3_iiss_rsel", 32'(rsel0), 32'd1);
        chk("t3_iiss_addr", dn_addr0, 32'h200);
        tick();
        dn_read_data = 32'h55;
        #1;
        chk("t3_idone_rdata", i_rdata0, 32'h55);
        chk("t3_idone_dhold", d_rdata0, 32'hAA);
        tick();
        i_read = 1'b0;

        // D write must not disturb the held D read result
        d_write = 1'b1;
        tick();
        tick();
        dn_read_data = 32'h77;
        #1;
        chk("t4_wdone_dbusy", 32'(d_busy0), 32'd0);
        chk("t4_wdone_dhold", d_rdata0, 32'hAA);
        tick();
        d_write = 1'b0; dn_read_data = 32'h0;
        #1;
        chk("t4_after_dhold", d_rdata0, 32'hAA);
        chk("t4_after_ihold", i_rdata0, 32'h55);

        // Illegal request: both read and write set on D
        d_read = 1'b1; d_write = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t5_ill_dbusy", 32'(d_busy0), 32'd0);
            chk("t5_ill_sel", {30'b0, rsel0, wsel0}, 32'd0);
            tick();
        end
        d_read = 1'b0; d_write = 1'b0;

        // Reset while a read is in flight, request kept pending across reset
        i_read = 1'b1; i_address = 32'h200;
        tick();
        #1;
        chk("t6_iss_rsel", 32'(rsel0), 32'd1);
        rst = 1'b0;
        #1;
        chk("t6_rst_rsel", 32'(rsel0), 32'd0);
        chk("t6_rst_irdata", i_rdata0, 32'h0);
        chk("t6_rst_drdata", d_rdata0, 32'h0);
        tick();
        rst = 1'b1;
        #1;
        chk("t6_rel_rsel", 32'(rsel0), 32'd0);
        chk("t6_rel_ibusy", 32'(i_busy0), 32'd1);
        tick();
        #1;
        chk("t6_reiss_rsel", 32'(rsel0), 32'd1);
        chk("t6_reiss_addr", dn_addr0, 32'h200);
        tick();
        #1;
        chk("t6_done_ibusy", 32'(i_busy0), 32'd0);
        tick();
        i_read = 1'b0;

        // Fixed priority versus round-robin on conflicts
        pulse_reset();
        i_read = 1'b1; d_read = 1'b1; i_address = 32'h200; d_address = 32'h400;
        tick();
        #1;
        chk("t7_c1_grant_rr", 32'(grant0), 32'd0);
        chk("t7_c1_grant_fp", 32'(grant1), 32'd1);
        chk("t7_c1_addr_fp", dn_addr1, 32'h400);
        i_read = 1'b0; d_read = 1'b0;
        tick();
        tick();
        i_read = 1'b1; d_read = 1'b1;
        tick();
        #1;
        chk("t7_c2_grant_rr", 32'(grant0), 32'd1);
        chk("t7_c2_grant_fp", 32'(grant1), 32'd1);
        chk("t7_c2_rsel_fp", 32'(rsel1), 32'd1);
        tick();
        tick();
        #1;
        chk("t7_b2b_grant_fp", 32'(grant1), 32'd0);
        chk("t7_b2b_rsel_fp", 32'(rsel1), 32'd1);
        i_read = 1'b0; d_read = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
